// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the 32x64 register file between two
// writeback requesters: port 0 (ALU/execute) and port 1 (memory/load).
// At most one write is accepted per cycle. The accepted write is
// registered and driven onto the register file write port for one cycle.
// Writes to the zero register are accepted but never committed.
//
// Build option:
//   REGWR_ARB_RR_EN  defined   -> round-robin arbitration using a 1-bit
//                                 priority pointer (reset value 0).
//                    undefined -> fixed priority, port 0 wins collisions.
//
// Handshake: a write on port N transfers when reqN_valid && reqN_ready
// are both 1 at a rising clk edge. The requester holds valid/addr/data
// stable until accepted. ready is combinational from the valids, hold,
// reset and the priority pointer; it never depends on the output stage.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   hold           blocks all grants this cycle
//   req0_valid/addr/data, req0_ready   port 0 request and grant
//   req1_valid/addr/data, req1_ready   port 1 request and grant
//   RegWrite       register file write enable (registered)
//   WriteRegister  register file write index (registered)
//   WriteData      register file write data (registered)
//   commit_count   committed (non-zero-register) writes, wraps at 16 bits
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic [15:0]           commit_count
);

    localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    logic                  r_regwrite;
    logic [ADDR_WIDTH-1:0] r_wreg;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [15:0]           r_count;

`ifdef REGWR_ARB_RR_EN
    // Port that wins the next collision.
    logic                  r_prio;
`endif

    // Grant logic. Reset is included so both readies drop immediately
    // while reset is asserted and recover in the same cycle it releases.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset && !hold) begin
`ifdef REGWR_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                w_grant0 = ~r_prio;
                w_grant1 = r_prio;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
`else
            w_grant0 = req0_valid;
            w_grant1 = req1_valid & ~req0_valid;
`endif
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_accept   = w_grant0 | w_grant1;
    assign w_sel_addr = w_grant1 ? req1_addr : req0_addr;
    assign w_sel_data = w_grant1 ? req1_data : req0_data;
    // Zero-register writes complete the handshake but do not commit.
    assign w_commit   = w_accept && (w_sel_addr != ZR);

    // Output stage: one-cycle registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
        end else begin
            r_regwrite <= w_commit;
            if (w_accept) begin
                r_wreg  <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
            if (w_commit) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

`ifdef REGWR_ARB_RR_EN
    // After serving port k the other port gets priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_grant0) begin
            r_prio <= 1'b1;
        end else if (w_grant1) begin
            r_prio <= 1'b0;
        end
    end
`endif

    assign RegWrite      = r_regwrite;
    assign WriteRegister = r_wreg;
    assign WriteData     = r_wdata;
    assign commit_count  = r_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are sampled a further time unit later,
// well away from the next edge. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          hold;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic [15:0]   commit_count;

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ZERO_REG  (31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .commit_count (commit_count)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ready(input string tag, input logic e0, input logic e1);
        check({tag, "_ready0"}, 64'(req0_ready), 64'(e0));
        check({tag, "_ready1"}, 64'(req1_ready), 64'(e1));
    endtask

    task automatic check_out(input string tag, input logic ew, input logic [AW-1:0] ea,
                             input logic [DW-1:0] ed, input logic [15:0] ec);
        check({tag, "_regwrite"}, 64'(RegWrite), 64'(ew));
        check({tag, "_wreg"}, 64'(WriteRegister), 64'(ea));
        check({tag, "_wdata"}, 64'(WriteData), 64'(ed));
        check({tag, "_count"}, 64'(commit_count), 64'(ec));
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        exp_cnt = 16'd0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b1;
        hold       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
        exp_cnt    = 16'd0;

        // Reset state
        #2;
        check_ready("rst", 1'b0, 1'b0);
        check_out("rst", 1'b0, 5'd0, 64'd0, 16'd0);
        step();
        step();
        reset = 1'b0;

        // Single port-0 write
        step();
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 64'hDEAD_BEEF;
        #1;
        check_ready("t1", 1'b1, 1'b0);
        step();
        req0_valid = 1'b0;
        exp_cnt = 16'd1;
        check_out("t1_out", 1'b1, 5'd5, 64'hDEAD_BEEF, exp_cnt);
        step();
        check_out("t1_idle", 1'b0, 5'd5, 64'hDEAD_BEEF, exp_cnt);

        // Both ports valid for 4 cycles, starting from a fresh reset
        pulse_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd1;
        req0_data  = 64'h11;
        req1_valid = 1'b1;
        req1_addr  = 5'd2;
        req1_data  = 64'h22;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef REGWR_ARB_RR_EN
            check_ready($sformatf("t2_c%0d", i), (i % 2) == 0, (i % 2) == 1);
            step();
            exp_cnt = exp_cnt + 16'd1;
            if ((i % 2) == 0)
                check_out($sformatf("t2_o%0d", i), 1'b1, 5'd1, 64'h11, exp_cnt);
            else
                check_out($sformatf("t2_o%0d", i), 1'b1, 5'd2, 64'h22, exp_cnt);
`else
            check_ready($sformatf("t2_c%0d", i), 1'b1, 1'b0);
            step();
            exp_cnt = exp_cnt + 16'd1;
            check_out($sformatf("t2_o%0d", i), 1'b1, 5'd1, 64'h11, exp_cnt);
`endif
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Port-1 write to the zero register: accepted, not committed
        req1_valid = 1'b1;
        req1_addr  = 5'd31;
        req1_data  = 64'h1234;
        #1;
        check_ready("t3", 1'b0, 1'b1);
        step();
        req1_valid = 1'b0;
        check_out("t3_out", 1'b0, 5'd31, 64'h1234, exp_cnt);

        // hold with both valid for 3 cycles
        hold       = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 5'd7;
        req0_data  = 64'h77;
        req1_valid = 1'b1;
        req1_addr  = 5'd8;
        req1_data  = 64'h88;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ready($sformatf("t4_h%0d", i), 1'b0, 1'b0);
            step();
            check_out($sformatf("t4_o%0d", i), 1'b0, 5'd31, 64'h1234, exp_cnt);
        end
        hold = 1'b0;
        #1;
        check_ready("t4_rel", 1'b1, 1'b0);
        step();
        req0_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check_out("t4_g0", 1'b1, 5'd7, 64'h77, exp_cnt);
        #1;
        check_ready("t4_p1", 1'b0, 1'b1);
        step();
        req1_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check_out("t4_g1", 1'b1, 5'd8, 64'h88, exp_cnt);

        // Asynchronous reset while RegWrite is high
        req0_valid = 1'b1;
        req0_addr  = 5'd9;
        req0_data  = 64'h99;
        step();
        exp_cnt = exp_cnt + 16'd1;
        check_out("t5_pre", 1'b1, 5'd9, 64'h99, exp_cnt);
        req0_addr = 5'd10;
        req0_data = 64'hA0;
        #1;
        reset = 1'b1;
        #1;
        exp_cnt = 16'd0;
        check_out("t5_rst", 1'b0, 5'd0, 64'd0, exp_cnt);
        check_ready("t5_rst", 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_ready("t5_rel", 1'b1, 1'b0);
        step();
        exp_cnt = 16'd1;
        check_out("t5_post", 1'b1, 5'd10, 64'hA0, exp_cnt);

        // Counter wrap: fill to 0xFFFF, then one more write
        req0_addr = 5'd3;
        req0_data = 64'h3;
        repeat (int'(16'hFFFF - exp_cnt)) step();
        exp_cnt = 16'hFFFF;
        check("t6_full", 64'(commit_count), 64'(exp_cnt));
        step();
        req0_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check_out("t6_wrap", 1'b1, 5'd3, 64'h3, exp_cnt);
        step();
        check("t6_idle", 64'(RegWrite), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
